// File: rtl/cpu_if.sv
// cpu_if: ROM and board-facing signals of the cpu.
interface cpu_if;
  logic [3:0] address;
  logic [7:0] instr;
  logic [3:0] port_in;
  logic [3:0] port_out;
  modport master(output address, port_out, input instr, port_in);
  modport slave(input address, port_out, output instr, port_in);
endinterface

// File: rtl/cpu.sv
// cpu: 4-bit accumulator cpu executing one ROM instruction per clock.
module cpu (
  input logic clk,
  input logic reset,
  cpu_if.master bus
);
  logic [3:0] pc, a, b, out_r, op, im, src;
  logic carry;
  logic [4:0] sum;
  assign op = bus.instr[7:4];
  assign im = bus.instr[3:0];
  // sel_a = op[0]|op[3], sel_b = op[1]; both set selects zero
  assign src = (op[0] | op[3]) ? (op[1] ? 4'd0 : b) : (op[1] ? bus.port_in : a);
  assign sum = {1'b0, src} + {1'b0, im};
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
      a <= '0;
      b <= '0;
      out_r <= '0;
      carry <= 1'b0;
    end else begin
      carry <= sum[4];
      if (!op[3] && !op[2]) a <= sum[3:0];
      if (!op[3] && op[2]) b <= sum[3:0];
      if (op[3] && !op[2]) out_r <= sum[3:0];
      pc <= (op[3] && op[2] && (!carry || op[0])) ? im : pc + 4'd1;
    end
  end
  assign bus.address = pc;
  assign bus.port_out = out_r;
endmodule

// File: tb/tb_cpu.sv
// tb_cpu: vector table, random run against an ISA-level model, and the timer program.
module tb_cpu;
  logic clk = 1'b0;
  logic reset;
  cpu_if bus();
  cpu dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [3:0] m_pc, m_a, m_b, m_out;
  logic m_c;

  typedef struct {
    logic [7:0] instr;
    logic [3:0] pin;
    logic [3:0] addr;
    logic [3:0] out;
  } vec_t;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference semantics written per mnemonic, not per decode signal
  task automatic model_step(input logic [7:0] ins, input logic [3:0] pin, input bit rst);
    int n, s;
    logic [3:0] npc;
    if (rst) begin
      m_pc = 0; m_a = 0; m_b = 0; m_out = 0; m_c = 0;
      return;
    end
    n = int'(ins[3:0]);
    npc = m_pc + 4'd1;
    case (ins[7:4])
      4'h0: begin s = int'(m_a) + n; m_a = 4'(s); end
      4'h1: begin s = int'(m_b) + n; m_a = 4'(s); end
      4'h2: begin s = int'(pin) + n; m_a = 4'(s); end
      4'h3: begin s = n; m_a = 4'(s); end
      4'h4: begin s = int'(m_a) + n; m_b = 4'(s); end
      4'h5: begin s = int'(m_b) + n; m_b = 4'(s); end
      4'h6: begin s = int'(pin) + n; m_b = 4'(s); end
      4'h7: begin s = n; m_b = 4'(s); end
      4'h8, 4'h9: begin s = int'(m_b) + n; m_out = 4'(s); end
      4'hA, 4'hB: begin s = n; m_out = 4'(s); end
      4'hC: begin s = int'(m_b) + n; if (!m_c) npc = 4'(n); end
      4'hD: begin s = int'(m_b) + n; npc = 4'(n); end
      4'hE: begin s = n; if (!m_c) npc = 4'(n); end
      default: begin s = n; npc = 4'(n); end
    endcase
    m_c = (s > 15);
    m_pc = npc;
  endtask

  task automatic cycle(input logic [7:0] ins, input logic [3:0] pin, input bit rst);
    bus.instr = ins;
    bus.port_in = pin;
    reset = rst;
    model_step(ins, pin, rst);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[19];
  logic [7:0] rom[16];
  logic [3:0] seen[$];
  logic [3:0] want[$];
  logic [3:0] prev;
  logic [7:0] ri;
  logic [3:0] rp;
  bit rr;

  initial begin
    reset = 1'b1;
    bus.instr = '0;
    bus.port_in = '0;
    vecs = '{
      '{8'h33, 4'h0, 4'd1, 4'h0}, '{8'h41, 4'h0, 4'd2, 4'h0},
      '{8'h92, 4'h0, 4'd3, 4'h6}, '{8'hB9, 4'h0, 4'd4, 4'h9},
      '{8'h21, 4'h5, 4'd5, 4'h9}, '{8'h40, 4'h0, 4'd6, 4'h9},
      '{8'h90, 4'h0, 4'd7, 4'h6}, '{8'h60, 4'hF, 4'd8, 4'h6},
      '{8'h3F, 4'h0, 4'd9, 4'h6}, '{8'h01, 4'h0, 4'd10, 4'h6},
      '{8'hE5, 4'h0, 4'd11, 4'h6}, '{8'hE5, 4'h0, 4'd5, 4'h6},
      '{8'hFA, 4'h0, 4'd10, 4'h6}, '{8'h7F, 4'h0, 4'd11, 4'h6},
      '{8'hD1, 4'h0, 4'd1, 4'h6}, '{8'hC4, 4'h0, 4'd2, 4'h6},
      '{8'hC4, 4'h0, 4'd3, 4'h6}, '{8'h70, 4'h0, 4'd4, 4'h6},
      '{8'hC4, 4'h0, 4'd4, 4'h6}};
    rom = '{8'hB7, 8'h01, 8'hE1, 8'h01, 8'hE3, 8'hB6, 8'h01, 8'hE6,
            8'h01, 8'hE8, 8'hB0, 8'hB4, 8'h01, 8'hEA, 8'hB8, 8'hFF};

    cycle(8'hA5, 4'h3, 1'b1);
    chk("reset_addr", bus.address, 4'd0);
    chk("reset_out", bus.port_out, 4'd0);
    for (int i = 0; i < 16; i++) begin
      cycle(8'h00, 4'h0, 1'b0);
      chk("pc_wrap", bus.address, 4'((i + 1) % 16));
    end

    cycle(8'h00, 4'h0, 1'b1);
    foreach (vecs[i]) begin
      cycle(vecs[i].instr, vecs[i].pin, 1'b0);
      chk($sformatf("vec%0d_addr", i), bus.address, vecs[i].addr);
      chk($sformatf("vec%0d_out", i), bus.port_out, vecs[i].out);
    end

    for (int i = 0; i < 1500; i++) begin
      ri = 8'($urandom);
      rp = 4'($urandom);
      rr = ($urandom_range(0, 49) == 0);
      cycle(ri, rp, rr);
      chk("rand_addr", bus.address, m_pc);
      chk("rand_out", bus.port_out, m_out);
    end

    cycle(8'h3F, 4'h0, 1'b0);
    cycle(8'h01, 4'h0, 1'b0);
    cycle(8'hFA, 4'h0, 1'b1);
    chk("reset_prio_addr", bus.address, 4'd0);
    cycle(8'hE5, 4'h0, 1'b0);
    chk("reset_clears_carry", bus.address, 4'd5);

    cycle(8'h00, 4'h5, 1'b1);
    prev = bus.port_out;
    for (int i = 0; i < 400; i++) begin
      cycle(rom[bus.address], 4'b0101, 1'b0);
      if (i == 0) chk("prog_first_out", bus.port_out, 4'b0111);
      chk("prog_addr", bus.address, m_pc);
      if (bus.port_out !== prev) seen.push_back(bus.port_out);
      prev = bus.port_out;
    end
    want.push_back(4'd7);
    want.push_back(4'd6);
    for (int i = 0; i < 16; i++) begin
      want.push_back(4'd0);
      want.push_back(4'd4);
    end
    want.push_back(4'd8);
    chk("prog_seq_len", 4'(seen.size()), 4'(want.size()));
    if (seen.size() != want.size()) begin
      checks++;
      errors++;
      $display("FAIL prog_seq_size: got %0d expected %0d", seen.size(), want.size());
    end
    for (int i = 0; i < want.size() && i < seen.size(); i++)
      chk($sformatf("prog_seq%0d", i), seen[i], want[i]);
    chk("prog_final_out", bus.port_out, 4'b1000);
    chk("prog_final_addr", bus.address, 4'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
